// File: rtl/clb_config_loader_pkg.sv
// Shared definitions for the CLB configuration loader: FSM states and parameter defaults.
package clb_cfg_pkg;

    localparam int unsigned CONFIG_BITS_DEFAULT = 32;
    localparam logic [7:0]  SYNC_WORD_DEFAULT   = 8'hA5;

    typedef enum logic [2:0] {
        HUNT,
        PAYLOAD,
        CHECK,
        COMMIT,
        ERR
    } cfg_state_e;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/clb_config_loader_if.sv
// Serial configuration bus between a bitstream source (master) and the loader (slave).
interface clb_config_loader_if
    import clb_cfg_pkg::*;
#(
    parameter int unsigned CONFIG_BITS = CONFIG_BITS_DEFAULT
);
    logic                   cfg_valid;
    logic                   cfg_data;
    logic                   cfg_ready;
    logic                   cfg_abort;
    logic [CONFIG_BITS-1:0] cfg_word;
    logic                   cfg_loaded;
    logic                   cfg_done;
    logic                   cfg_error;
    logic [3:0]             err_count;

    modport master (
        output cfg_valid, cfg_data, cfg_abort,
        input  cfg_ready, cfg_word, cfg_loaded, cfg_done, cfg_error, err_count
    );

    modport slave (
        input  cfg_valid, cfg_data, cfg_abort,
        output cfg_ready, cfg_word, cfg_loaded, cfg_done, cfg_error, err_count
    );
endinterface

// File: rtl/clb_config_loader_sync_hunter.sv
// Frame sync detector: 8-bit shift history compared against the sync pattern.
module cfg_sync_hunter
    import clb_cfg_pkg::*;
#(
    parameter logic [7:0] SYNC_WORD = SYNC_WORD_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic shift_i,
    input  logic bit_i,
    output logic match_o
);
    logic [7:0] hist_q, hist_d;

    always_comb begin
        hist_d  = {hist_q[6:0], bit_i};
        match_o = shift_i && (hist_d == SYNC_WORD);
    end

    // History is wiped on a match so a later hunt never reuses bits of this frame.
    always_ff @(posedge clk) begin
        if (reset || clear_i || match_o) begin
            hist_q <= '0;
        end else if (shift_i) begin
            hist_q <= hist_d;
        end
    end
endmodule

// File: rtl/clb_config_loader.sv
// Serial CLB configuration loader: sync hunt, MSB-first payload, even-parity check, commit.
module clb_config_loader
    import clb_cfg_pkg::*;
#(
    parameter int unsigned CONFIG_BITS = CONFIG_BITS_DEFAULT,
    parameter logic [7:0]  SYNC_WORD   = SYNC_WORD_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    clb_config_loader_if.slave  cfg
);
    localparam int unsigned    CW   = $clog2(CONFIG_BITS);
    localparam logic [CW-1:0]  LAST = CW'(CONFIG_BITS - 1);

    cfg_state_e             state_q, state_d;
    logic [CONFIG_BITS-1:0] shadow_q, shadow_d;
    logic [CONFIG_BITS-1:0] word_q, word_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   par_q, par_d;
    logic                   loaded_q, loaded_d;
    logic                   done_q, done_d;
    logic                   error_q, error_d;
    logic [3:0]             errs_q, errs_d;
    logic                   ready;
    logic                   accept;
    logic                   sync_match;

    assign ready  = !reset && (state_q inside {HUNT, PAYLOAD, CHECK});
    assign accept = cfg.cfg_valid && ready;

    cfg_sync_hunter #(
        .SYNC_WORD (SYNC_WORD)
    ) u_hunter (
        .clk     (clk),
        .reset   (reset),
        .clear_i (cfg.cfg_abort || (state_q != HUNT)),
        .shift_i (accept && !cfg.cfg_abort && (state_q == HUNT)),
        .bit_i   (cfg.cfg_data),
        .match_o (sync_match)
    );

    // Result outputs are loaded on the edge entering COMMIT/ERR so they are valid during that state.
    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        word_d   = word_q;
        loaded_d = loaded_q;
        done_d   = 1'b0;
        error_d  = 1'b0;
        errs_d   = errs_q;
        if (cfg.cfg_abort) begin
            state_d  = HUNT;
            shadow_d = '0;
            cnt_d    = '0;
            par_d    = 1'b0;
        end else begin
            unique case (state_q)
                HUNT: begin
                    if (sync_match) state_d = PAYLOAD;
                end
                PAYLOAD: begin
                    if (accept) begin
                        shadow_d = {shadow_q[CONFIG_BITS-2:0], cfg.cfg_data};
                        par_d    = par_q ^ cfg.cfg_data;
                        if (cnt_q == LAST) begin
                            cnt_d   = '0;
                            state_d = CHECK;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                CHECK: begin
                    if (accept) begin
                        if ((par_q ^ cfg.cfg_data) == 1'b0) begin
                            state_d  = COMMIT;
                            word_d   = shadow_q;
                            loaded_d = 1'b1;
                            done_d   = 1'b1;
                        end else begin
                            state_d = ERR;
                            error_d = 1'b1;
                            errs_d  = sat_inc4(errs_q);
                        end
                    end
                end
                COMMIT, ERR: begin
                    state_d  = HUNT;
                    shadow_d = '0;
                    cnt_d    = '0;
                    par_d    = 1'b0;
                end
                default: state_d = HUNT;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HUNT;
            shadow_q <= '0;
            word_q   <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            loaded_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            errs_q   <= '0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            word_q   <= word_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            loaded_q <= loaded_d;
            done_q   <= done_d;
            error_q  <= error_d;
            errs_q   <= errs_d;
        end
    end

    assign cfg.cfg_ready  = ready;
    assign cfg.cfg_word   = word_q;
    assign cfg.cfg_loaded = loaded_q;
    assign cfg.cfg_done   = done_q;
    assign cfg.cfg_error  = error_q;
    assign cfg.err_count  = errs_q;
endmodule
